// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for mem_port_arbiter (FSM states, grant ids, wait-counter width)
package mem_arb_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, ACK} state_e;
  typedef enum logic {GNT_IF, GNT_D} gnt_e;
  localparam int CNT_W = 3;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant select; ports if_req, d_req, last_gnt (only with ARB_ROUND_ROBIN_EN: alternate on contention) -> gnt; default data-over-fetch priority
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  gnt_e last_gnt,
`endif
  output gnt_e gnt
);
`ifdef ARB_ROUND_ROBIN_EN
  assign gnt = (if_req && (!d_req || last_gnt == GNT_D)) ? GNT_IF : GNT_D;
`else
  assign gnt = (d_req || !if_req) ? GNT_D : GNT_IF;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch (if_req/if_addr -> if_rdata/if_ack) and data (d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack) word accesses onto one memory port (mem_addr/mem_wdata/mem_rd/mem_wr, mem_rdata after RD_LATENCY); all outputs registered; ARB_ROUND_ROBIN_EN selects round-robin contention
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [31:0]           if_rdata,
  output logic                  if_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic [31:0]           d_rdata,
  output logic                  d_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic [31:0]           mem_rdata
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  gnt_e gnt_q, gnt_d, pick_gnt;
  logic we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic rd_q, rd_d, wr_q, wr_d, if_ack_q, if_ack_d, d_ack_q, d_ack_d;
`ifdef ARB_ROUND_ROBIN_EN
  gnt_e last_q, last_d;
`endif
  mem_arb_pick u_pick (
    .if_req(if_req),
    .d_req(d_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_gnt(last_q),
`endif
    .gnt(pick_gnt)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    gnt_d = gnt_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_d = 1'b0;
    wr_d = 1'b0;
    if_ack_d = 1'b0;
    d_ack_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d = last_q;
`endif
    case (state_q)
      IDLE: if (if_req || d_req) begin
        gnt_d = pick_gnt;
        we_d = pick_gnt == GNT_D && d_we;
        addr_d = pick_gnt == GNT_D ? d_addr : if_addr;
        wdata_d = pick_gnt == GNT_D ? d_wdata : wdata_q;
        rd_d = !we_d;
        wr_d = we_d;
        state_d = ISSUE;
      end
      ISSUE: if (we_q) begin
        state_d = ACK;
        if_ack_d = gnt_q == GNT_IF;
        d_ack_d = gnt_q == GNT_D;
      end else if (RD_LATENCY == 1) begin
        state_d = CAPTURE;
      end else begin
        state_d = WAIT;
        cnt_d = CNT_W'(RD_LATENCY - 1);
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        state_d = cnt_q == CNT_W'(1) ? CAPTURE : WAIT;
      end
      CAPTURE: begin
        rdata_d = mem_rdata;
        state_d = ACK;
        if_ack_d = gnt_q == GNT_IF;
        d_ack_d = gnt_q == GNT_D;
      end
      ACK: begin
        state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
        last_d = gnt_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      gnt_q <= GNT_D;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      if_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q <= GNT_D;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      if_ack_q <= if_ack_d;
      d_ack_q <= d_ack_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q <= last_d;
`endif
    end
  end
  assign if_rdata = rdata_q;
  assign d_rdata = rdata_q;
  assign if_ack = if_ack_q;
  assign d_ack = d_ack_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd = rd_q;
  assign mem_wr = wr_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench driving a RD_LATENCY=1 and a RD_LATENCY=3 arbiter with directed transactions
module tb_mem_port_arbiter;
  logic clk = 0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int errors = 0, checks = 0, done = 0;
  typedef struct {logic is_d; logic [31:0] data; int due;} ack_t;
  typedef struct {logic wr; logic [31:0] addr; logic [31:0] wdata;} stb_t;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = g == 0 ? 1 : 3;
    logic reset = 1'b1, if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic if_ack, d_ack, mem_rd, mem_wr;
    logic [31:0] cap_word = '0, pre_word = '0, exp_rdata = '0;
    int k = 99;
    ack_t aq[$];
    stb_t sq[$];
    mem_port_arbiter #(.ADDR_WIDTH(32), .RD_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_rdata(mem_rdata)
    );
    always @(negedge clk) begin
      k = mem_rd ? 0 : (k < 99 ? k + 1 : k);
      mem_rdata = k == LAT ? cap_word : pre_word;
    end
    always @(negedge clk) begin : mon
      stb_t s;
      ack_t a;
      if (mem_rd || mem_wr) begin
        if (sq.size() == 0) check($sformatf("L%0d stray strobe", LAT), 1, 0);
        else begin
          s = sq.pop_front();
          check($sformatf("L%0d strobe rd/wr", LAT), {mem_rd, mem_wr}, {!s.wr, s.wr});
          check($sformatf("L%0d mem_addr", LAT), mem_addr, s.addr);
          if (s.wr) check($sformatf("L%0d mem_wdata", LAT), mem_wdata, s.wdata);
        end
      end
      if (if_ack || d_ack) begin
        if (aq.size() == 0) check($sformatf("L%0d stray ack", LAT), {if_ack, d_ack}, 0);
        else begin
          a = aq.pop_front();
          check($sformatf("L%0d ack owner", LAT), {if_ack, d_ack}, {!a.is_d, a.is_d});
          check($sformatf("L%0d if_rdata", LAT), if_rdata, a.data);
          check($sformatf("L%0d d_rdata", LAT), d_rdata, a.data);
          if (a.due >= 0) check($sformatf("L%0d ack cycle", LAT), cyc, a.due);
        end
      end
    end
    function automatic void push(input logic is_d, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int due);
      sq.push_back('{we, addr, wdata});
      if (!we) exp_rdata = cap_word;
      aq.push_back('{is_d, exp_rdata, due});
    endfunction
    task automatic check_zero(input string tag);
      check($sformatf("L%0d %s strobes/acks", LAT, tag), {if_ack, d_ack, mem_rd, mem_wr}, 0);
      check($sformatf("L%0d %s if_rdata", LAT, tag), if_rdata, 0);
      check($sformatf("L%0d %s d_rdata", LAT, tag), d_rdata, 0);
      check($sformatf("L%0d %s mem_addr", LAT, tag), mem_addr, 0);
      check($sformatf("L%0d %s mem_wdata", LAT, tag), mem_wdata, 0);
    endtask
    task automatic xact(input logic is_d, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      push(is_d, we, addr, wdata, cyc + (we ? 2 : LAT + 2));
      if (is_d) begin
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
        if_req = 1'b1; if_addr = addr;
      end
      for (int i = 0; i < 40 && !(is_d ? d_ack : if_ack); i++) @(negedge clk);
      if (!(is_d ? d_ack : if_ack)) check($sformatf("L%0d ack timeout", LAT), 0, 1);
      @(negedge clk);
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
    endtask
    initial begin
      int n;
      logic isd;
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;
      @(negedge clk);
      cap_word = 32'hDEADBEEF;
      xact(1'b0, 1'b0, 32'h10, 32'h0);
      xact(1'b1, 1'b1, 32'h20, 32'h12345678);
      pre_word = 32'hAAAA0000;
      cap_word = 32'h5555FFFF;
      xact(1'b1, 1'b0, 32'h24, 32'h0);
      cap_word = 32'h0BADF00D;
      for (int i = 0; i < 4; i++) begin
        isd = RR ? (i % 2 == 1) : 1'b1;
        push(isd, isd, isd ? 32'h20 : 32'h30, isd ? 32'hCAFEF00D : 32'h0, -1);
      end
      if_addr = 32'h30; d_addr = 32'h20; d_we = 1'b1; d_wdata = 32'hCAFEF00D;
      if_req = 1'b1; d_req = 1'b1;
      n = 0;
      for (int i = 0; i < 200 && n < 4; i++) begin
        @(negedge clk);
        if (if_ack || d_ack) n++;
      end
      if (n < 4) check($sformatf("L%0d contention acks", LAT), n, 4);
      @(negedge clk);
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      repeat (2) @(negedge clk);
      if_addr = 32'h50; if_req = 1'b1;
      sq.push_back('{1'b0, 32'h50, 32'h0});
      for (int i = 0; i < 20 && !mem_rd; i++) @(negedge clk);
      @(negedge clk);
      reset = 1'b1; if_req = 1'b0;
      @(negedge clk);
      check_zero("abort");
      reset = 1'b0;
      exp_rdata = '0;
      repeat (2) @(negedge clk);
      cap_word = 32'h13579BDF;
      xact(1'b0, 1'b0, 32'h60, 32'h0);
      repeat (8) @(negedge clk);
      check($sformatf("L%0d pending acks", LAT), aq.size(), 0);
      check($sformatf("L%0d pending strobes", LAT), sq.size(), 0);
      done++;
    end
  end
  initial begin
    for (int i = 0; i < 20000 && done < 2; i++) @(negedge clk);
    if (done < 2) check("run completion", done, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single synchronous memory port between an instruction-fetch requester and a load/store data requester.
- Serialises one word transaction at a time.
- Drives mem_rd/mem_wr strobes and address/data, waits the memory's fixed read latency, and returns read data with a one-cycle ack.
- Sits between the rv32 core's fetch/load-store sequencing and the memory.

Parameters:
- ADDR_WIDTH, 32: width of word address on all address ports.
- RD_LATENCY, 1: cycles between the mem_rd cycle and the mem_rdata sample edge; legal 1..7.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_WIDTH  fetch word address, stable while if_req
- if_rdata  out  32  fetch read data, valid in if_ack cycle
- if_ack  out  1  one-cycle completion pulse to fetch
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1=write, 0=read; stable while d_req
- d_addr  in  ADDR_WIDTH  data word address
- d_wdata  in  32  store data
- d_rdata  out  32  load data, valid in d_ack cycle
- d_ack  out  1  one-cycle completion pulse to data
- mem_addr  out  ADDR_WIDTH  memory word address
- mem_wdata  out  32  memory write data
- mem_rd  out  1  read strobe
- mem_wr  out  1  write strobe
- mem_rdata  in  32  memory read data

Behaviour:
- One clock (clk); reset synchronous, active-high. All outputs are registered.
- Reset values: every output 0. State IDLE. Wait counter 0. Last-grant = DATA.
- Reset asserted in any state aborts the transaction: no ack, no strobe next cycle, return to IDLE.
- States:
  - IDLE: sample if_req/d_req; no request -> stay.
  - Grant (see priority) -> latch addr/wdata/we into mem_addr/mem_wdata; assert mem_rd (read) or mem_wr (write) for the next cycle; -> ISSUE.
  - ISSUE (strobe high, cycle T; strobe lasts exactly one cycle):
    - Write -> ACK.
    - Read, RD_LATENCY=1 -> CAPTURE.
    - Read, RD_LATENCY>1 -> WAIT with counter loaded RD_LATENCY-1.
  - WAIT: decrement counter; at 1 -> CAPTURE. Strobes low.
  - CAPTURE (cycle T+RD_LATENCY): sample mem_rdata into the shared rdata register at the ending edge -> ACK.
  - ACK: pulse granted requester's ack for one cycle; update last-grant -> IDLE. Requests are not sampled in ACK, so a req still high in the ack cycle is never double-serviced.
- Latency:
  - Read: req seen in IDLE cycle T-1 -> ack visible cycle T+RD_LATENCY+1 (RD_LATENCY+2 cycles).
  - Write: ack visible cycle T+1 (2 cycles).
- Back-to-back: new request accepted earliest in the cycle after ack. Minimum spacing between strobes is RD_LATENCY+3 cycles for reads and 3 cycles for writes.
- if_rdata and d_rdata are both driven from the shared rdata register; content is meaningful only with the matching ack.
- Write ack leaves rdata unchanged.
- mem_addr/mem_wdata hold their last value outside transactions.
- Fetch requests are always reads.
- Requester dropping req before ack: undefined by protocol; arbiter completes the transaction and still pulses ack.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous if_req and d_req in IDLE, grant the requester not last granted. Lone requests are granted immediately. Last-grant resets to DATA, so fetch wins the first contention.
- Undefined: fixed priority, data over fetch. Last-grant register is not built.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding (IDLE, ISSUE, WAIT, CAPTURE, ACK);
  - grant encoding (GNT_IF, GNT_D);
  - counter width constant (3 bits).
- Sub-module mem_arb_pick: combinational grant selector taking both reqs and last-grant, returning the grant. Priority versus round-robin is confined there under the macro.

Test Plan:
- Lone fetch, RD_LATENCY=1: if_req addr 0x10, mem_rdata=0xDEADBEEF in CAPTURE -> mem_rd high exactly one cycle with mem_addr=0x10; if_ack one cycle 3 cycles after req sampled; if_rdata=0xDEADBEEF; d_ack stays 0.
- Data write: d_req, d_we=1, addr 0x20, wdata 0x12345678 -> mem_wr one cycle with those values, mem_rd 0; d_ack next cycle; rdata unchanged.
- Contention, both reqs held, reqs re-raised after each ack for 4 transactions:
  - macro off -> order D,D,D,D while d_req stays high, fetch starved;
  - macro on -> order IF,D,IF,D.
- RD_LATENCY=3 read: mem_rdata=0xAAAA0000 in cycles T+1..T+2, 0x5555FFFF in T+3 -> ack at T+4 with rdata 0x5555FFFF.
- Reset asserted during WAIT -> next cycle all outputs 0, no ack ever issued for the aborted request; subsequent if_req serviced normally with standard latency.
- Requester holds req through the ack cycle, then drops it -> exactly one strobe and one ack.
